// File: rtl/timer_pkg.sv
// Shared definitions for the target/compare timer: FSM states, compare
// mode encodings and the legal WIDTH range.
package timer_pkg;

  localparam int unsigned WIDTH_MIN = 4;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_e;

  // Compare modes; MODE_RSVD decodes the same as MODE_GE.
  localparam logic [1:0] MODE_GE   = 2'b00;
  localparam logic [1:0] MODE_EQ   = 2'b01;
  localparam logic [1:0] MODE_GT   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/mag_compare.sv
// Unsigned magnitude comparator.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : a > b
//   eq   : a == b
module mag_compare #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/target_compare_timer.sv
// Tick-driven up-counter compared against a loadable target. A hit either
// parks the timer in HIT (one-shot) or restarts the count (auto-reload).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   tick              : count enable while running
//   start/stop/clear  : control pulses (priority clear > stop > start)
//   target_load       : capture target_in into the target register
//   target_in         : new compare target
//   mode              : 00 >=, 01 ==, 10 >, 11 treated as >=
//   auto_reload       : restart from 0 on a hit instead of entering HIT
//   count             : registered count
//   running           : state is RUN
//   match_pulse       : one-cycle pulse per hit event
//   match_sticky      : set by any hit, cleared by clear/rst
//   overflow          : sticky wrap flag
module target_compare_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned RELOAD_DEFAULT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             target_load,
  input  logic [WIDTH-1:0] target_in,
  input  logic [1:0]       mode,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             match_pulse,
  output logic             match_sticky,
  output logic             overflow
);

  // Elaboration-time parameter legality. Integrations that tie auto_reload
  // off are expected to tie it to RELOAD_DEFAULT; the live input governs.
  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("target_compare_timer: WIDTH out of range");
  end
  if (RELOAD_DEFAULT > 1) begin : g_bad_reload
    $error("target_compare_timer: RELOAD_DEFAULT must be 0 or 1");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic              match_pulse_q, match_pulse_d;
  logic              match_sticky_q, match_sticky_d;
  logic              overflow_q, overflow_d;
  logic              gt_c, eq_c, hit_c;

  // Compare uses registered count and target only.
  mag_compare #(.WIDTH(WIDTH)) u_cmp (
    .a  (count_q),
    .b  (target_q),
    .gt (gt_c),
    .eq (eq_c)
  );

  // Mode mux; the reserved encoding falls back to >=.
  always_comb begin
    hit_c = gt_c | eq_c;
    case (mode)
      MODE_EQ: hit_c = eq_c;
      MODE_GT: hit_c = gt_c;
      default: hit_c = gt_c | eq_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (clear || stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN:  if (hit_c && !auto_reload) state_d = HIT;
        HIT:  if (start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath next values. Start while in RUN is ignored, so the
  // RUN branch only looks at hit and tick.
  always_comb begin
    count_d        = count_q;
    match_pulse_d  = 1'b0;
    match_sticky_d = match_sticky_q;
    overflow_d     = overflow_q;
    target_d       = target_load ? target_in : target_q;
    if (clear) begin
      count_d        = '0;
      match_sticky_d = 1'b0;
      overflow_d     = 1'b0;
    end else if (!stop) begin
      case (state_q)
        HIT: begin
          if (start) count_d = '0;
        end
        RUN: begin
          if (hit_c) begin
            match_pulse_d  = 1'b1;
            match_sticky_d = 1'b1;
            if (auto_reload) count_d = '0;
          end else if (tick) begin
            count_d = count_q + WIDTH'(1);
            if (&count_q) overflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q        <= '0;
      target_q       <= '1;
      match_pulse_q  <= 1'b0;
      match_sticky_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      count_q        <= count_d;
      target_q       <= target_d;
      match_pulse_q  <= match_pulse_d;
      match_sticky_q <= match_sticky_d;
      overflow_q     <= overflow_d;
    end
  end

  assign count        = count_q;
  assign running      = (state_q == RUN);
  assign match_pulse  = match_pulse_q;
  assign match_sticky = match_sticky_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_target_compare_timer.sv
// Bench for target_compare_timer: a 16-bit and an 8-bit instance share the
// stimulus; a behavioural model predicts each cycle's outputs into a queue
// that a negedge monitor drains, while scenario tasks add directed checks.
module tb_target_compare_timer;

  logic        clk = 1'b0;
  logic        rst, tick, start, stop, clear, target_load, auto_reload;
  logic [1:0]  mode;
  logic [15:0] target_in;
  logic [7:0]  target_in8;

  logic [15:0] count16;
  logic        running16, pulse16, sticky16, ovf16;
  logic [7:0]  count8;
  logic        running8, pulse8, sticky8, ovf8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign target_in8 = target_in[7:0];

  target_compare_timer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .target_load(target_load), .target_in(target_in),
    .mode(mode), .auto_reload(auto_reload), .count(count16),
    .running(running16), .match_pulse(pulse16), .match_sticky(sticky16),
    .overflow(ovf16)
  );

  target_compare_timer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .target_load(target_load), .target_in(target_in8),
    .mode(mode), .auto_reload(auto_reload), .count(count8),
    .running(running8), .match_pulse(pulse8), .match_sticky(sticky8),
    .overflow(ovf8)
  );

  // Behavioural model state: st 0=idle 1=run 2=hit.
  typedef struct {
    int          st;
    logic [31:0] cnt;
    logic [31:0] tgt;
    bit          pulse;
    bit          sticky;
    bit          ovf;
  } mdl_t;

  typedef struct {
    logic [19:0] v16;  // {count, running, pulse, sticky, overflow}
    logic [11:0] v8;
  } exp_t;

  mdl_t m16, m8;
  exp_t sb[$];

  function automatic mdl_t mstep(mdl_t m, int unsigned w);
    mdl_t        n;
    logic [31:0] mask;
    bit          hit;
    mask    = (32'd1 << w) - 32'd1;
    n       = m;
    n.pulse = 1'b0;
    case (mode)
      2'b01:   hit = (m.cnt == m.tgt);
      2'b10:   hit = (m.cnt >  m.tgt);
      default: hit = (m.cnt >= m.tgt);
    endcase
    if (rst) begin
      n.st = 0; n.cnt = 0; n.tgt = mask; n.sticky = 1'b0; n.ovf = 1'b0;
      return n;
    end
    if (target_load) n.tgt = 32'(target_in) & mask;
    if (clear) begin
      n.st = 0; n.cnt = 0; n.ovf = 1'b0; n.sticky = 1'b0;
    end else if (stop) begin
      n.st = 0;
    end else if (start && m.st == 0) begin
      n.st = 1;
    end else if (start && m.st == 2) begin
      n.st = 1; n.cnt = 0;
    end else if (m.st == 1) begin
      if (hit) begin
        n.pulse = 1'b1; n.sticky = 1'b1;
        if (auto_reload) n.cnt = 0;
        else n.st = 2;
      end else if (tick) begin
        if (m.cnt == mask) n.ovf = 1'b1;
        n.cnt = (m.cnt + 32'd1) & mask;
      end
    end
    return n;
  endfunction

  // One clock: predict, push, let the edge happen, release the pulses.
  task automatic drive_cycle();
    exp_t e;
    m16   = mstep(m16, 16);
    m8    = mstep(m8, 8);
    e.v16 = {m16.cnt[15:0], (m16.st == 1), m16.pulse, m16.sticky, m16.ovf};
    e.v8  = {m8.cnt[7:0], (m8.st == 1), m8.pulse, m8.sticky, m8.ovf};
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; target_load = 1'b0;
  endtask

  // Scoreboard drain, away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] a16;
    logic [11:0] a8;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      a16 = {count16, running16, pulse16, sticky16, ovf16};
      a8  = {count8, running8, pulse8, sticky8, ovf8};
      checks++;
      if (a16 !== e.v16) begin
        errors++;
        $display("FAIL sb16 t=%0t got=%h exp=%h {count,run,pulse,sticky,ovf}", $time, a16, e.v16);
      end
      checks++;
      if (a8 !== e.v8) begin
        errors++;
        $display("FAIL sb8 t=%0t got=%h exp=%h {count,run,pulse,sticky,ovf}", $time, a8, e.v8);
      end
    end
  end

  task automatic load_target(input logic [15:0] t);
    target_in = t; target_load = 1'b1; drive_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_cycle();
    drive_cycle();
    checks++;
    if ({count16, running16, pulse16, sticky16, ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL reset16 got count=%h run=%b pulse=%b sticky=%b ovf=%b exp all zero",
               count16, running16, pulse16, sticky16, ovf16);
    end
    checks++;
    if ({count8, running8, pulse8, sticky8, ovf8} !== 12'h0) begin
      errors++;
      $display("FAIL reset8 got count=%h run=%b exp all zero", count8, running8);
    end
  endtask

  task automatic test_oneshot();
    int np = 0;
    clear = 1'b1; drive_cycle();
    mode = 2'b00; auto_reload = 1'b0; tick = 1'b0;
    load_target(16'd5);
    start = 1'b1; tick = 1'b1; drive_cycle();
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      if (pulse16 === 1'b1) np++;
    end
    checks++;
    if (np !== 1) begin errors++; $display("FAIL oneshot_pulses got=%0d exp=1", np); end
    checks++;
    if (count16 !== 16'd5 || running16 !== 1'b0 || sticky16 !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_hold got count=%0d run=%b sticky=%b exp 5 0 1", count16, running16, sticky16);
    end
    tick = 1'b0; start = 1'b1; drive_cycle();
    checks++;
    if (count16 !== 16'd0 || running16 !== 1'b1) begin
      errors++;
      $display("FAIL hit_restart got count=%0d run=%b exp 0 1", count16, running16);
    end
    stop = 1'b1; drive_cycle();
  endtask

  task automatic test_autoreload();
    int np = 0;
    clear = 1'b1; drive_cycle();
    mode = 2'b01; auto_reload = 1'b1; tick = 1'b0;
    load_target(16'd3);
    start = 1'b1; drive_cycle();
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_cycle();
      if (pulse16 === 1'b1) np++;
    end
    checks++;
    if (np !== 3) begin errors++; $display("FAIL reload_pulses got=%0d exp=3", np); end
    checks++;
    if (running16 !== 1'b1 || sticky16 !== 1'b1 || count16 !== 16'd0) begin
      errors++;
      $display("FAIL reload_state got run=%b sticky=%b count=%0d exp 1 1 0", running16, sticky16, count16);
    end
    tick = 1'b0; stop = 1'b1; drive_cycle();
  endtask

  task automatic test_wrap();
    int np = 0;
    clear = 1'b1; drive_cycle();
    mode = 2'b10; auto_reload = 1'b0; tick = 1'b0;
    load_target(16'd255);
    start = 1'b1; drive_cycle();
    tick = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive_cycle();
      if (pulse8 === 1'b1) np++;
    end
    checks++;
    if (count8 !== 8'd0 || ovf8 !== 1'b1 || np !== 0 || running8 !== 1'b1) begin
      errors++;
      $display("FAIL wrap8 got count=%0d ovf=%b pulses=%0d run=%b exp 0 1 0 1", count8, ovf8, np, running8);
    end
    tick = 1'b0; clear = 1'b1; drive_cycle();
    checks++;
    if (count8 !== 8'd0 || ovf8 !== 1'b0 || running8 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear got count=%0d ovf=%b run=%b exp 0 0 0", count8, ovf8, running8);
    end
  endtask

  task automatic test_start_stop_rst();
    clear = 1'b1; drive_cycle();
    start = 1'b1; stop = 1'b1; drive_cycle();
    checks++;
    if (running16 !== 1'b0 || running8 !== 1'b0) begin
      errors++;
      $display("FAIL start_stop got run16=%b run8=%b exp 0 0", running16, running8);
    end
    mode = 2'b00; auto_reload = 1'b0;
    load_target(16'hFFFF);
    start = 1'b1; drive_cycle();
    tick = 1'b1;
    for (int i = 0; i < 9; i++) drive_cycle();
    checks++;
    if (count16 !== 16'd9) begin errors++; $display("FAIL run_to_9 got=%0d exp=9", count16); end
    rst = 1'b1; drive_cycle();
    checks++;
    if ({count16, running16, pulse16, sticky16, ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL mid_run_rst got count=%0d run=%b pulse=%b sticky=%b ovf=%b exp all zero",
               count16, running16, pulse16, sticky16, ovf16);
    end
    start = 1'b1; drive_cycle();
    for (int i = 0; i < 3; i++) drive_cycle();
    tick = 1'b0; stop = 1'b1; drive_cycle();
  endtask

  task automatic test_target_load();
    clear = 1'b1; drive_cycle();
    mode = 2'b00; auto_reload = 1'b0; tick = 1'b0;
    load_target(16'd100);
    start = 1'b1; drive_cycle();
    tick = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle();
    checks++;
    if (count16 !== 16'd4) begin errors++; $display("FAIL tl_count4 got=%0d exp=4", count16); end
    load_target(16'd2);
    checks++;
    if (pulse16 !== 1'b0 || count16 !== 16'd5) begin
      errors++;
      $display("FAIL tl_same_edge got pulse=%b count=%0d exp 0 5", pulse16, count16);
    end
    drive_cycle();
    checks++;
    if (pulse16 !== 1'b1 || running16 !== 1'b0) begin
      errors++;
      $display("FAIL tl_next_hit got pulse=%b run=%b exp 1 0", pulse16, running16);
    end
    tick = 1'b0; clear = 1'b1; drive_cycle();
    mode = 2'b11;
    load_target(16'd2);
    start = 1'b1; drive_cycle();
    tick = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle();
    checks++;
    if (pulse16 !== 1'b1 || count16 !== 16'd2 || running16 !== 1'b0) begin
      errors++;
      $display("FAIL mode11 got pulse=%b count=%0d run=%b exp 1 2 0", pulse16, count16, running16);
    end
    tick = 1'b0;
  endtask

  task automatic test_back_to_back();
    int np = 0;
    clear = 1'b1; drive_cycle();
    mode = 2'b00; auto_reload = 1'b1;
    load_target(16'd0);
    start = 1'b1; tick = 1'b1; drive_cycle();
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      if (pulse16 === 1'b1) np++;
    end
    checks++;
    if (np !== 5 || count16 !== 16'd0) begin
      errors++;
      $display("FAIL t0_every_cycle got pulses=%0d count=%0d exp 5 0", np, count16);
    end
    tick = 1'b0; stop = 1'b1; drive_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      clear       = ($urandom_range(0, 31) == 0);
      start       = ($urandom_range(0, 7) == 0);
      stop        = ($urandom_range(0, 15) == 0);
      target_load = ($urandom_range(0, 15) == 0);
      target_in   = 16'($urandom_range(0, 40));
      mode        = 2'($urandom_range(0, 3));
      auto_reload = 1'($urandom_range(0, 1));
      tick        = ($urandom_range(0, 3) != 0);
      drive_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    target_load = 1'b0; auto_reload = 1'b0; mode = 2'b00; target_in = 16'h0;
    #1;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_wrap();
    test_start_stop_rst();
    test_target_load();
    test_back_to_back();
    test_random();
    @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d entries exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/target_compare_timer.md
TARGET_COMPARE_TIMER -- requirements
Module: target_compare_timer

Interface
REQ-001 Parameter WIDTH, default 16, sets the counter, target and comparator width in bits, legal range 4..32.
REQ-002 Parameter RELOAD_DEFAULT, default 0, sets the reset value of the auto-reload enable.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 tick  input  1  count enable; while RUN, one tick adds one count.
REQ-006 start  input  1  pulse; IDLE->RUN, or HIT->RUN after the count is cleared.
REQ-007 stop  input  1  pulse; RUN->IDLE, count holds.
REQ-008 clear  input  1  pulse; count:=0, overflow:=0, match_sticky:=0, state:=IDLE.
REQ-009 target_load  input  1  pulse; target_q := target_in.
REQ-010 target_in  input  WIDTH  new compare target, unsigned.
REQ-011 mode  input  2  compare mode: 00 count>=target, 01 count==target, 10 count>target, 11 reserved and treated as 00.
REQ-012 auto_reload  input  1  1 = on a hit, the count restarts from 0 and the timer stays in RUN.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 running  output  1  high while state==RUN.
REQ-015 match_pulse  output  1  registered; one cycle per hit event.
REQ-016 match_sticky  output  1  set by any hit; cleared only by clear or rst.
REQ-017 overflow  output  1  sticky; set when count wraps from all-ones to 0.

Function
REQ-018 hit SHALL be the combinational value cmp(count_q, target_q, mode), unsigned, using the registered values only.
REQ-019 States SHALL be IDLE, RUN and HIT.
REQ-020 Input priority each cycle SHALL be, highest first: rst, clear, stop, start, then the hit/tick actions.
REQ-021 IDLE: count SHALL hold; start SHALL move to RUN on the next edge; hit SHALL be ignored.
REQ-022 RUN, hit=1: match_pulse:=1 and match_sticky:=1 on that edge. If auto_reload=1, count:=0 (tick ignored) and the state stays RUN. If auto_reload=0, state:=HIT and count holds.
REQ-023 RUN, hit=0, tick=1: count := count+1 modulo 2^WIDTH. Wrap from all-ones to 0 SHALL set overflow.
REQ-024 RUN, hit=0, tick=0: count SHALL hold.
REQ-025 HIT: count SHALL hold. start SHALL set count:=0 and state:=RUN. stop SHALL move to IDLE.
REQ-026 match_pulse SHALL be 0 in every cycle not covered by REQ-022. Latency from count_q satisfying hit to match_pulse high SHALL be exactly 1 cycle.
REQ-027 target_load in any state SHALL update target_q on the same edge; the new value affects hit from the next cycle.
REQ-028 start and stop asserted together SHALL act as stop. start while already in RUN SHALL have no effect.
REQ-029 With auto_reload=1, mode 00 and target T, hits SHALL recur every T+1 RUN cycles that have tick=1. T=0 SHALL give a hit every RUN cycle.
REQ-030 The auto_reload input SHALL be sampled in the same cycle as the hit.

Reset
REQ-031 rst SHALL set: state=IDLE, count=0, target_q=all-ones, match_pulse=0, match_sticky=0, overflow=0, running=0.
REQ-032 rst asserted mid-RUN or in HIT SHALL discard all progress; the next edge after rst deasserts SHALL observe IDLE.
REQ-033 RELOAD_DEFAULT SHALL apply only to the internal reload enable when auto_reload is tied off at integration; the auto_reload input SHALL otherwise always govern.

Structure
REQ-034 A shared package timer_pkg SHALL hold the state enum (IDLE, RUN, HIT), the mode encodings and the WIDTH legality bounds.
REQ-035 The compare SHALL be a single parametrised combinational sub-module, mag_compare, with WIDTH-wide a and b inputs and gt and eq outputs. The mode mux SHALL sit in target_compare_timer.
REQ-036 All outputs SHALL be driven directly from registers, except running, which SHALL be decoded from the state register.

Verification
REQ-037 WIDTH=16, mode 00, target 5, auto_reload 0, start, tick held high -> count reaches 5; match_pulse high for 1 cycle at the next edge; state HIT; count stays 5.
REQ-038 Mode 01, target 3, auto_reload 1, tick high for 12 cycles -> count sequence 0,1,2,3,0,1,2,3,...; match_pulse every 4th cycle; match_sticky=1; running stays 1.
REQ-039 WIDTH=8, mode 10, target 255, tick high -> count wraps 255->0 with overflow=1 and no match_pulse; then clear -> count=0, overflow=0, IDLE.
REQ-040 start and stop asserted in the same cycle from IDLE -> state stays IDLE. Then rst asserted mid-RUN at count 9 -> next cycle count=0, target=0xFFFF, all flags 0.
REQ-041 target_load to 2 at count 4 in RUN, mode 00 -> hit on the following cycle and match_pulse one cycle later. Then mode 11 with target 2 -> behaves identically to mode 00.
